// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 encryption control FSM.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD_WAIT,
        ST_AD,
        ST_PT_WAIT,
        ST_PT,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [3:0] P12_FIRST  = 4'd0;
    localparam logic [3:0] P6_FIRST   = 4'd6;
    localparam logic [3:0] ROUND_LAST = 4'd11;

    // Round shown while waiting for a PT block. The last block goes straight
    // into the p12 finalisation, so it starts at round 0 instead of 6.
    function automatic logic [3:0] pt_wait_round(input logic [3:0] pt_rem);
        return (pt_rem <= 4'd1) ? P12_FIRST : P6_FIRST;
    endfunction

endpackage

// File: rtl/ascon_fsm_ctrl_if.sv
// Block source handshake towards the ASCON control FSM (start, counts, block valid/ready).
// Latency: n/a (signal bundle only).
// Backpressure: block_rdy is driven by the FSM; the source holds block_vld until it is seen.
interface ascon_fsm_ctrl_if;

    logic       start;
    logic [3:0] ad_blocks;
    logic [3:0] pt_blocks;
    logic       block_vld;
    logic       block_rdy;

    modport master (output start, output ad_blocks, output pt_blocks, output block_vld,
                    input  block_rdy);
    modport slave  (input  start, input  ad_blocks, input  pt_blocks, input  block_vld,
                    output block_rdy);

endinterface

// File: rtl/ascon_round_counter.sv
// 4-bit permutation round index with load, increment and last-round flag.
// Latency: new value visible one cycle after load/enable.
// Backpressure: none; holds its value when neither load nor enable is set.
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    logic [3:0] round_q;
    logic [3:0] round_d;

    // Next round: load wins over increment; increment saturates at the last round.
    always_comb begin
        round_d = round_q;
        if (load_i) begin
            round_d = load_val_i;
        end else if (en_i && (round_q < ROUND_LAST)) begin
            round_d = round_q + 4'd1;
        end
    end

    // Round register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o = round_q;
    assign last_o  = (round_q == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 encryption control: sequences p12 init, p6 per AD/PT block, p12 final + tag.
// Latency: 12 + 6/AD block + 6/non-last PT block + 12 cycles, +1 per stalled wait cycle.
// Backpressure: stalls in AD_WAIT/PT_WAIT with block_rdy high until block_vld; build option ASCON_ABORT_EN adds abort_i.
module ascon_fsm_ctrl
    import ascon_pack::*;
(
    input  logic            clock_i,
    input  logic            resetb_i,
`ifdef ASCON_ABORT_EN
    input  logic            abort_i,
`endif
    ascon_fsm_ctrl_if.slave bus,
    output logic            data_sel_o,
    output logic            en_xor_data_o,
    output logic            en_xor_key_o,
    output logic            en_xor_key_end_o,
    output logic            en_xor_lsb_o,
    output logic            en_reg_state_o,
    output logic            en_cipher_o,
    output logic            en_tag_o,
    output logic [3:0]      round_o,
    output logic            busy_o,
    output logic            cipher_valid_o,
    output logic            done_o
);

    state_t     state_q, state_d;
    logic [3:0] ad_rem_q, ad_rem_d;
    logic [3:0] pt_rem_q, pt_rem_d;
    logic       cipher_valid_q;
    logic       cnt_load, cnt_inc, cnt_last;
    logic [3:0] cnt_val, round;
    logic       rdy, abort;

`ifdef ASCON_ABORT_EN
    assign abort = abort_i && (state_q != ST_IDLE);
`else
    assign abort = 1'b0;
`endif

    ascon_round_counter u_round (
        .clock_i    (clock_i),
        .rst_i      (resetb_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_inc),
        .round_o    (round),
        .last_o     (cnt_last)
    );

    // Output decode from registered state/round, next-state and counter control.
    // Only the handshake enables in the WAIT states look at block_vld directly.
    always_comb begin
        state_d          = state_q;
        ad_rem_d         = ad_rem_q;
        pt_rem_d         = pt_rem_q;
        cnt_load         = 1'b0;
        cnt_val          = P12_FIRST;
        cnt_inc          = 1'b0;
        rdy              = 1'b0;
        data_sel_o       = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_reg_state_o   = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        done_o           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ad_rem_d = bus.ad_blocks;
                    pt_rem_d = (bus.pt_blocks == 4'd0) ? 4'd1 : bus.pt_blocks;
                    cnt_load = 1'b1;
                    cnt_val  = P12_FIRST;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = (round != P12_FIRST);
                cnt_inc        = 1'b1;
                if (cnt_last) begin
                    en_xor_key_end_o = 1'b1;
                    cnt_load         = 1'b1;
                    if (ad_rem_q == 4'd0) begin
                        en_xor_lsb_o = 1'b1;
                        cnt_val      = pt_wait_round(pt_rem_q);
                        state_d      = ST_PT_WAIT;
                    end else begin
                        cnt_val = P6_FIRST;
                        state_d = ST_AD_WAIT;
                    end
                end
            end
            ST_AD_WAIT: begin
                rdy        = 1'b1;
                data_sel_o = 1'b1;
                if (bus.block_vld) begin
                    en_xor_data_o  = 1'b1;
                    en_reg_state_o = 1'b1;
                    cnt_inc        = 1'b1;
                    state_d        = ST_AD;
                end
            end
            ST_AD: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                cnt_inc        = 1'b1;
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    if (ad_rem_q != 4'd0) begin
                        ad_rem_d = ad_rem_q - 4'd1;
                    end
                    if (ad_rem_q <= 4'd1) begin
                        en_xor_lsb_o = 1'b1;
                        cnt_val      = pt_wait_round(pt_rem_q);
                        state_d      = ST_PT_WAIT;
                    end else begin
                        cnt_val = P6_FIRST;
                        state_d = ST_AD_WAIT;
                    end
                end
            end
            ST_PT_WAIT: begin
                rdy        = 1'b1;
                data_sel_o = 1'b1;
                if (bus.block_vld) begin
                    en_xor_data_o  = 1'b1;
                    en_cipher_o    = 1'b1;
                    en_reg_state_o = 1'b1;
                    cnt_inc        = 1'b1;
                    if (pt_rem_q != 4'd0) begin
                        pt_rem_d = pt_rem_q - 4'd1;
                    end
                    if (pt_rem_q <= 4'd1) begin
                        en_xor_key_o = 1'b1;
                        state_d      = ST_FINAL;
                    end else begin
                        state_d = ST_PT;
                    end
                end
            end
            ST_PT: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                cnt_inc        = 1'b1;
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    cnt_val  = pt_wait_round(pt_rem_q);
                    state_d  = ST_PT_WAIT;
                end
            end
            ST_FINAL: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                cnt_inc        = 1'b1;
                if (cnt_last) begin
                    en_xor_key_end_o = 1'b1;
                    en_tag_o         = 1'b1;
                    cnt_load         = 1'b1;
                    cnt_val          = P12_FIRST;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_load = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
        // Abort takes effect at the next edge; the round index is cleared with it.
        if (abort) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
            cnt_val  = P12_FIRST;
            cnt_inc  = 1'b0;
        end
    end

    // FSM state, remaining-block counts and the ciphertext-valid pulse.
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state_q        <= ST_IDLE;
            ad_rem_q       <= '0;
            pt_rem_q       <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ad_rem_q       <= ad_rem_d;
            pt_rem_q       <= pt_rem_d;
            cipher_valid_q <= en_cipher_o && !abort;
        end
    end

    assign bus.block_rdy  = rdy;
    assign round_o        = round;
    assign busy_o         = (state_q != ST_IDLE);
    assign cipher_valid_o = cipher_valid_q;

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Scoreboard bench for ascon_fsm_ctrl: expected per-cycle outputs are queued per run,
// a negedge monitor pops one entry for every busy cycle and checks the done edge.
// Build with ASCON_ABORT_EN defined to also exercise abort_i.
module tb_ascon_fsm_ctrl;

    typedef struct packed {
        logic       rdy, sel, xd, xk, xke, xl, rs, ci, tg;
        logic [3:0] rnd;
        logic       cv, dn;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic data_sel_o, en_xor_data_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o;
    logic en_reg_state_o, en_cipher_o, en_tag_o, busy_o, cipher_valid_o, done_o;
    logic [3:0] round_o;

    ascon_fsm_ctrl_if bus ();

    ascon_fsm_ctrl dut (
        .clock_i          (clk),
        .resetb_i         (rst),
`ifdef ASCON_ABORT_EN
        .abort_i          (abort),
`endif
        .bus              (bus),
        .data_sel_o       (data_sel_o),
        .en_xor_data_o    (en_xor_data_o),
        .en_xor_key_o     (en_xor_key_o),
        .en_xor_key_end_o (en_xor_key_end_o),
        .en_xor_lsb_o     (en_xor_lsb_o),
        .en_reg_state_o   (en_reg_state_o),
        .en_cipher_o      (en_cipher_o),
        .en_tag_o         (en_tag_o),
        .round_o          (round_o),
        .busy_o           (busy_o),
        .cipher_valid_o   (cipher_valid_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];
    int   done_q[$];
    int   edge_cnt = 0;
    int   stall_left = 0;
    logic mon_en = 1'b0;
    out_t mon_act, mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t sample();
        return {bus.block_rdy, data_sel_o, en_xor_data_o, en_xor_key_o, en_xor_key_end_o,
                en_xor_lsb_o, en_reg_state_o, en_cipher_o, en_tag_o, round_o,
                cipher_valid_o, done_o};
    endfunction

    // Expected busy-cycle trace of one encryption; 'cut' keeps only the first entries
    // (interrupted runs), 'done_edge' counts edges with the start-sampling edge as 1.
    task automatic push_run(input int ad, input int pt, input int stall, input int cut,
                            input int done_edge);
        out_t t[$];
        out_t e;
        int   np;
        np = (pt == 0) ? 1 : pt;
        for (int r = 0; r < 12; r++) begin
            e = '0; e.rs = 1'b1; e.sel = (r != 0); e.rnd = 4'(r);
            if (r == 11) begin e.xke = 1'b1; e.xl = (ad == 0); end
            t.push_back(e);
        end
        for (int b = 0; b < ad; b++) begin
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    e = '0; e.rdy = 1'b1; e.sel = 1'b1; e.rnd = 4'd6; t.push_back(e);
                end
            end
            e = '0; e.rdy = 1'b1; e.sel = 1'b1; e.xd = 1'b1; e.rs = 1'b1; e.rnd = 4'd6;
            t.push_back(e);
            for (int r = 7; r < 12; r++) begin
                e = '0; e.sel = 1'b1; e.rs = 1'b1; e.rnd = 4'(r);
                e.xl = (r == 11) && (b == ad - 1);
                t.push_back(e);
            end
        end
        for (int b = 0; b < np; b++) begin
            e = '0; e.rdy = 1'b1; e.sel = 1'b1; e.xd = 1'b1; e.rs = 1'b1; e.ci = 1'b1;
            if (b == np - 1) begin e.xk = 1'b1; e.rnd = 4'd0; end
            else e.rnd = 4'd6;
            t.push_back(e);
            if (b != np - 1) begin
                for (int r = 7; r < 12; r++) begin
                    e = '0; e.sel = 1'b1; e.rs = 1'b1; e.rnd = 4'(r); e.cv = (r == 7);
                    t.push_back(e);
                end
            end
        end
        for (int r = 1; r < 12; r++) begin
            e = '0; e.sel = 1'b1; e.rs = 1'b1; e.rnd = 4'(r); e.cv = (r == 1);
            if (r == 11) begin e.xke = 1'b1; e.tg = 1'b1; end
            t.push_back(e);
        end
        e = '0; e.dn = 1'b1; t.push_back(e);
        if (cut == 0) cut = t.size();
        for (int i = 0; i < cut; i++) exp_q.push_back(t[i]);
        if (done_edge != 0) done_q.push_back(done_edge);
    endtask

    // Edge count since the edge that sampled start (that edge itself is 1).
    always @(posedge clk) begin
        if (bus.start && !busy_o && !rst) edge_cnt <= 1;
        else edge_cnt <= edge_cnt + 1;
    end

    // Source valid: high unless a stall is requested while the FSM is ready.
    initial begin
        bus.block_vld = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.block_rdy && stall_left > 0) begin
                bus.block_vld = 1'b0;
                stall_left--;
            end else begin
                bus.block_vld = 1'b1;
            end
        end
    end

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && busy_o) begin
            mon_act = sample();
            if (exp_q.size() == 0) begin
                chk("unexpected_busy_cycle", 32'(mon_act), 32'hffff_ffff);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("trace", 32'(mon_act), 32'(mon_exp));
            end
            if (done_o) begin
                if (done_q.size() == 0) chk("unexpected_done", 32'(edge_cnt), 32'hffff_ffff);
                else chk("done_edge", 32'(edge_cnt), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic do_start(input logic [3:0] ad, input logic [3:0] pt);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ad_blocks = ad; bus.pt_blocks = pt;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 32'(n >= 400), 32'd0);
        @(negedge clk);
        chk("idle_outputs", 32'({sample(), busy_o}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0;
        bus.start = 1'b0; bus.ad_blocks = 4'd0; bus.pt_blocks = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_outputs", 32'({sample(), busy_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(sample()), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_round", 32'(round_o), 32'd0);
        mon_en = 1'b1;

        // AD=1, PT=4, valid always high.
        push_run(1, 4, 0, 0, 49);
        do_start(4'd1, 4'd4);
        wait_drain("run_ad1_pt4");

        // AD=0, PT=1; a start pulse mid-run must be ignored.
        push_run(0, 1, 0, 0, 25);
        do_start(4'd0, 4'd1);
        repeat (5) @(posedge clk);
        #1; bus.start = 1'b1; bus.ad_blocks = 4'd3; bus.pt_blocks = 4'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_drain("run_ad0_pt1");

        // Five-cycle stall in the first AD_WAIT: done moves from 49 to 54.
        stall_left = 5;
        push_run(1, 4, 5, 0, 54);
        do_start(4'd1, 4'd4);
        wait_drain("run_stall5");

        // Multiple AD and PT blocks.
        push_run(2, 2, 0, 0, 43);
        do_start(4'd2, 4'd2);
        wait_drain("run_ad2_pt2");

        // PT=0 behaves as one block; reset lands on FINAL round 4 (17th busy cycle).
        push_run(0, 0, 0, 17, 0);
        do_start(4'd0, 4'd0);
        repeat (16) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_outputs", 32'({sample(), busy_o}), 32'd0);
        chk("mid_reset_trace_used", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;

        // Fresh run after the reset, maximum AD count.
        push_run(15, 1, 0, 0, 115);
        do_start(4'd15, 4'd1);
        wait_drain("run_ad15_pt1");

`ifdef ASCON_ABORT_EN
        // Abort during PT round 8 (15th busy cycle): IDLE next cycle, no done.
        push_run(0, 2, 0, 15, 0);
        do_start(4'd0, 4'd2);
        repeat (14) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs", 32'({sample(), busy_o}), 32'd0);
        chk("abort_trace_used", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({done_o, busy_o}), 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
